// File: rtl/rect_draw_pkg.sv
// Shared types and constants for the rectangle command sequencer.
// Holds the screen size, the packed draw command, the FSM state encoding
// and a helper that trims a span so it stops at the screen edge.
package rect_draw_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;

  // One draw command: origin, size and RGB444 colour (52 bits in total)
  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [9:0]  w;
    logic [9:0]  h;
    logic [11:0] color;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    START = 2'd2,
    WAIT  = 2'd3
  } seq_state_t;

  // Shorten len so that pos+len does not pass limit; sums are taken in
  // 11 bits so that a 10-bit origin plus a 10-bit size cannot wrap.
  // Only meaningful when pos < limit, which validation guarantees.
  function automatic logic [9:0] clipLen(input logic [9:0]  pos,
                                         input logic [9:0]  len,
                                         input logic [10:0] limit);
    logic [10:0] farEdge;
    logic [10:0] room;
    farEdge = {1'b0, pos} + {1'b0, len};
    room    = limit - {1'b0, pos};
    if (farEdge > limit) begin
      return room[9:0];
    end
    return len;
  endfunction

endpackage

// File: rtl/rect_cmd_fifo.sv
// Synchronous command FIFO for the rectangle sequencer.
// DEPTH entries of rect_cmd_t; read and write pointers are $clog2(DEPTH)
// bits wide and simply wrap, while a separate registered count tells full
// from empty. The head entry is visible combinationally on o_head.
module rect_cmd_fifo
  import rect_draw_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    i_push,
  input  rect_cmd_t               i_pushData,
  input  logic                    i_pop,
  output rect_cmd_t               o_head,
  output logic [$clog2(DEPTH):0]  o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  rect_cmd_t     r_mem [DEPTH];
  logic [PW-1:0] r_wrPtr;
  logic [PW-1:0] r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_doPush;
  logic          w_doPop;

  // A push into a full FIFO or a pop from an empty one is ignored here as
  // a second line of defence; the sequencer never requests either.
  assign w_doPush = i_push && (r_count != CW'(DEPTH));
  assign w_doPop  = i_pop  && (r_count != '0);

  // Storage array; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_pushData;
    end
  end

  // Pointer and occupancy bookkeeping; a simultaneous push and pop leaves
  // the count where it was
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rdPtr];
  assign o_count = r_count;

endmodule

// File: rtl/rect_cmd_sequencer.sv
// Rectangle command sequencer: front end of the rectangle generator.
// Accepts draw commands over valid/ready, queues them, rejects commands
// that are empty or start off-screen, and hands the rest one at a time to
// the generator, holding gen_* steady until the generator reports done.
// Build option: define CLIP_EN to trim width/height to the visible screen
// before issue; without it sizes pass unchanged and the generator is
// trusted to stop at the screen edge itself.
module rect_cmd_sequencer #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = rect_draw_pkg::SCREEN_W,
  parameter int SCREEN_H = rect_draw_pkg::SCREEN_H
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [9:0]              cmd_x,
  input  logic [9:0]              cmd_y,
  input  logic [9:0]              cmd_w,
  input  logic [9:0]              cmd_h,
  input  logic [11:0]             cmd_color,
  output logic [9:0]              gen_x,
  output logic [9:0]              gen_y,
  output logic [9:0]              gen_w,
  output logic [9:0]              gen_h,
  output logic [11:0]             gen_color,
  output logic                    gen_start,
  input  logic                    gen_done,
  output logic                    busy,
  output logic [$clog2(DEPTH):0]  queue_count,
  output logic [7:0]              drop_count
);

  import rect_draw_pkg::*;

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [10:0] W_LIMIT = 11'(SCREEN_W);
  localparam logic [10:0] H_LIMIT = 11'(SCREEN_H);

  seq_state_t    r_state;
  rect_cmd_t     r_gen;
  logic          r_genStart;
  logic [7:0]    r_dropCount;
  logic          r_readyEn;

  rect_cmd_t     w_pushData;
  rect_cmd_t     w_head;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count;
  logic          w_reject;
  logic [9:0]    w_issueW;
  logic [9:0]    w_issueH;

  assign w_pushData = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, color: cmd_color};

  // Ready is held low during reset and for the rest of that cycle, then
  // follows the registered occupancy so a push can never hit a full queue.
  assign cmd_ready = r_readyEn && (w_count < CW'(DEPTH));
  assign w_push    = cmd_valid && cmd_ready;

  // The FSM only pops in IDLE and only when the registered count says an
  // entry is present, so a freshly pushed command waits at least a cycle.
  assign w_pop = (r_state == IDLE) && (w_count != '0);

  rect_cmd_fifo #(
    .DEPTH      (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_push     (w_push),
    .i_pushData (w_pushData),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count)
  );

  // Validation of the command sitting in the output registers; the
  // comparisons are widened to 11 bits so 10-bit origins compare cleanly
  // against the screen limits.
  assign w_reject = (r_gen.w == '0) ||
                    (r_gen.h == '0) ||
                    ({1'b0, r_gen.x} >= W_LIMIT) ||
                    ({1'b0, r_gen.y} >= H_LIMIT);

`ifdef CLIP_EN
  assign w_issueW = clipLen(r_gen.x, r_gen.w, W_LIMIT);
  assign w_issueH = clipLen(r_gen.y, r_gen.h, H_LIMIT);
`else
  assign w_issueW = r_gen.w;
  assign w_issueH = r_gen.h;
`endif

  // Ready enable: first clock after reset release opens the input side
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readyEn <= 1'b0;
    end else begin
      r_readyEn <= 1'b1;
    end
  end

  // Issue FSM with registered gen_* outputs, start pulse and drop counter.
  // gen_* are only written when popping in IDLE and when clipping in
  // CHECK, so they cannot move during START or WAIT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_gen       <= '0;
      r_genStart  <= 1'b0;
      r_dropCount <= '0;
    end else begin
      r_genStart <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_count != '0) begin
            r_gen   <= w_head;
            r_state <= CHECK;
          end
        end
        CHECK: begin
          if (w_reject) begin
            if (r_dropCount != 8'hFF) begin
              r_dropCount <= r_dropCount + 8'd1;
            end
            r_state <= IDLE;
          end else begin
            r_gen.w    <= w_issueW;
            r_gen.h    <= w_issueH;
            r_genStart <= 1'b1;
            r_state    <= START;
          end
        end
        START: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (gen_done) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign gen_x       = r_gen.x;
  assign gen_y       = r_gen.y;
  assign gen_w       = r_gen.w;
  assign gen_h       = r_gen.h;
  assign gen_color   = r_gen.color;
  assign gen_start   = r_genStart;
  assign busy        = (r_state != IDLE) || (w_count != '0);
  assign queue_count = w_count;
  assign drop_count  = r_dropCount;

endmodule

// File: tb/tb_rect_cmd_sequencer.sv
// Self-checking bench for rect_cmd_sequencer.
// Commands are generated with $urandom and fed to a simple model: a queue
// of the draws that should be issued (already trimmed when CLIP_EN is
// defined) and a saturating count of commands that should be rejected.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_rect_cmd_sequencer;
  import rect_draw_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_x, cmd_y, cmd_w, cmd_h;
  logic [11:0] cmd_color;
  logic [9:0]  gen_x, gen_y, gen_w, gen_h;
  logic [11:0] gen_color;
  logic        gen_start;
  logic        gen_done;
  logic        busy;
  logic [3:0]  queue_count;
  logic [7:0]  drop_count;

  int total = 0;
  int bad   = 0;

  rect_cmd_t expQ[$];
  int        modelDrops = 0;

  always #5 clk = ~clk;

  rect_cmd_sequencer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h), .cmd_color(cmd_color),
    .gen_x(gen_x), .gen_y(gen_y), .gen_w(gen_w), .gen_h(gen_h), .gen_color(gen_color),
    .gen_start(gen_start), .gen_done(gen_done),
    .busy(busy), .queue_count(queue_count), .drop_count(drop_count)
  );

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Acceptance rule: non-empty and starting inside the visible screen
  function automatic bit cmdOk(input rect_cmd_t c);
    return (c.w != 0) && (c.h != 0) && (int'(c.x) < 640) && (int'(c.y) < 480);
  endfunction

  // What the generator should be handed for an accepted command
  function automatic rect_cmd_t expectedIssue(input rect_cmd_t c);
    rect_cmd_t e;
    e = c;
`ifdef CLIP_EN
    if (int'(c.x) + int'(c.w) > 640) e.w = 10'(640 - int'(c.x));
    if (int'(c.y) + int'(c.h) > 480) e.h = 10'(480 - int'(c.y));
`endif
    return e;
  endfunction

  function automatic rect_cmd_t randValid();
    rect_cmd_t c;
    c.x     = 10'($urandom_range(0, 639));
    c.y     = 10'($urandom_range(0, 479));
    c.w     = 10'($urandom_range(1, 1023));
    c.h     = 10'($urandom_range(1, 1023));
    c.color = 12'($urandom);
    return c;
  endfunction

  function automatic rect_cmd_t randAny();
    rect_cmd_t c;
    c.x     = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(600, 1023)) : 10'($urandom_range(0, 639));
    c.y     = ($urandom_range(0, 3) == 0) ? 10'($urandom_range(440, 1023)) : 10'($urandom_range(0, 479));
    c.w     = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 80));
    c.h     = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 80));
    c.color = 12'($urandom);
    return c;
  endfunction

  function automatic rect_cmd_t genNow();
    return {gen_x, gen_y, gen_w, gen_h, gen_color};
  endfunction

  // Offer one command until accepted (bounded) and record it in the model
  task automatic applyStimulus(input rect_cmd_t c);
    bit done;
    done      = 0;
    cmd_x     = c.x;
    cmd_y     = c.y;
    cmd_w     = c.w;
    cmd_h     = c.h;
    cmd_color = c.color;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200 && !done; i++) begin
      if (cmd_ready === 1'b1) done = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    if (done) begin
      if (cmdOk(c)) expQ.push_back(expectedIssue(c));
      else if (modelDrops < 255) modelDrops++;
    end else begin
      total++;
      bad++;
      $display("[TB] FAIL push_timeout: cmd_ready=%b after 200 cycles, need 1", cmd_ready);
    end
  endtask

  // Wait (bounded) for gen_start; reports cycles waited and gen_* seen
  task automatic waitStart(input int limit, output bit seen, output int cycles, output rect_cmd_t obs);
    seen   = 0;
    cycles = 0;
    obs    = '0;
    while (!seen && cycles <= limit) begin
      if (gen_start === 1'b1) begin
        seen = 1;
        obs  = genNow();
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
  endtask

  // Act as the generator: keep drawing for a while, then pulse gen_done
  task automatic finishDraw(input int holdCycles);
    repeat (holdCycles) @(negedge clk);
    gen_done = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit && busy !== 1'b0; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    gen_done  = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_color = '0;
    repeat (3) @(negedge clk);
    total++;
    if ({cmd_ready, gen_start, busy, genNow(), queue_count, drop_count} !== '0)
      begin bad++; $display("[TB] FAIL reset_outputs: ready=%b start=%b busy=%b gen=%h count=%0d drops=%0d, need all 0",
        cmd_ready, gen_start, busy, genNow(), queue_count, drop_count); end
    reset_n = 1'b1;
    total++;
    if (cmd_ready !== 1'b0) begin bad++; $display("[TB] FAIL ready_at_release: got %b need 0", cmd_ready); end
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_release: got %b need 1", cmd_ready); end
    expQ.delete();
    modelDrops = 0;
  endtask

  task automatic test_single;
    rect_cmd_t c, e, obs;
    bit seen;
    int cyc;
    c = '{x: 10'd10, y: 10'd20, w: 10'd4, h: 10'd3, color: 12'hF00};
    applyStimulus(c);
    total++;
    if (queue_count !== 4'd1) begin bad++; $display("[TB] FAIL single_count: got %0d need 1", queue_count); end
    e = expQ.pop_front();
    waitStart(10, seen, cyc, obs);
    total++;
    if (!seen || cyc != 2) begin bad++; $display("[TB] FAIL single_latency: seen=%b cycles=%0d need 1/2", seen, cyc); end
    total++;
    if (obs !== e) begin bad++; $display("[TB] FAIL single_fields: got %h need %h", obs, e); end
    for (int i = 0; i < int'($urandom_range(2, 6)); i++) begin
      @(negedge clk);
      total++;
      if (gen_start !== 1'b0 || busy !== 1'b1 || genNow() !== e)
        begin bad++; $display("[TB] FAIL single_hold: start=%b busy=%b gen=%h need 0/1/%h", gen_start, busy, genNow(), e); end
    end
    finishDraw(0);
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_fall: got %b need 0", busy); end
  endtask

  task automatic test_back_to_back;
    rect_cmd_t e, obs, extra;
    bit seen, accepted, first;
    int cyc;
    for (int i = 0; i < 9; i++) applyStimulus(randValid());
    total++;
    if (queue_count !== 4'd8 || cmd_ready !== 1'b0)
      begin bad++; $display("[TB] FAIL fill_full: count=%0d ready=%b need 8/0", queue_count, cmd_ready); end
    e = expQ.pop_front();
    total++;
    if (genNow() !== e) begin bad++; $display("[TB] FAIL fill_first_held: got %h need %h", genNow(), e); end
    extra     = randValid();
    cmd_x     = extra.x; cmd_y = extra.y; cmd_w = extra.w; cmd_h = extra.h; cmd_color = extra.color;
    cmd_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++;
      if (cmd_ready !== 1'b0 || queue_count !== 4'd8)
        begin bad++; $display("[TB] FAIL fill_blocked: ready=%b count=%0d need 0/8", cmd_ready, queue_count); end
    end
    gen_done = 1'b1;
    @(negedge clk);
    gen_done = 1'b0;
    accepted = 0;
    for (int i = 0; i < 10 && !accepted; i++) begin
      if (cmd_ready === 1'b1) accepted = 1;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    total++;
    if (!accepted) begin bad++; $display("[TB] FAIL fill_ninth_accept: ready never rose, need 1"); end
    else expQ.push_back(expectedIssue(extra));
    total++;
    if (queue_count !== 4'd8) begin bad++; $display("[TB] FAIL fill_refill_count: got %0d need 8", queue_count); end
    first = 1;
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      waitStart(20, seen, cyc, obs);
      total++;
      if (!seen || obs !== e) begin bad++; $display("[TB] FAIL fill_order: seen=%b got %h need %h", seen, obs, e); end
      if (!first) begin
        total++;
        if (cyc != 2) begin bad++; $display("[TB] FAIL b2b_gap: got %0d cycles need 2", cyc); end
      end
      first = 0;
      finishDraw($urandom_range(1, 4));
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL fill_idle: busy=%b need 0", busy); end
  endtask

  task automatic test_drops;
    rect_cmd_t c, e, obs;
    bit seen;
    int cyc;
    c = randValid(); c.w = '0;      applyStimulus(c);
    c = randValid(); c.h = '0;      applyStimulus(c);
    c = randValid(); c.x = 10'd640; applyStimulus(c);
    c = randValid(); c.y = 10'd480; applyStimulus(c);
    c = '{x: 10'd639, y: 10'd479, w: 10'd1, h: 10'd1, color: 12'($urandom)};
    applyStimulus(c);
    e = expQ.pop_front();
    waitStart(40, seen, cyc, obs);
    total++;
    if (!seen || obs !== e) begin bad++; $display("[TB] FAIL drop_next_valid: seen=%b got %h need %h", seen, obs, e); end
    total++;
    if (drop_count !== 8'(modelDrops)) begin bad++; $display("[TB] FAIL drop_count: got %0d need %0d", drop_count, modelDrops); end
    finishDraw(1);
    total++;
    if (busy !== 1'b0) begin bad++; $display("[TB] FAIL drop_idle: busy=%b need 0", busy); end
  endtask

  task automatic test_clip;
    rect_cmd_t c, e, obs;
    bit seen;
    int cyc;
    logic [9:0] needWH;
`ifdef CLIP_EN
    needWH = 10'd10;
`else
    needWH = 10'd20;
`endif
    c = '{x: 10'd630, y: 10'd470, w: 10'd20, h: 10'd20, color: 12'($urandom)};
    applyStimulus(c);
    e = expQ.pop_front();
    waitStart(10, seen, cyc, obs);
    total++;
    if (!seen || obs !== e) begin bad++; $display("[TB] FAIL clip_fields: seen=%b got %h need %h", seen, obs, e); end
    total++;
    if (gen_w !== needWH || gen_h !== needWH)
      begin bad++; $display("[TB] FAIL clip_size: got w=%0d h=%0d need %0d", gen_w, gen_h, needWH); end
    finishDraw(2);
  endtask

  task automatic test_spurious_done;
    rect_cmd_t e, obs;
    bit seen;
    int cyc;
    gen_done = 1'b1;
    repeat (2) @(negedge clk);
    gen_done = 1'b0;
    total++;
    if (busy !== 1'b0 || gen_start !== 1'b0 || queue_count !== 4'd0)
      begin bad++; $display("[TB] FAIL spurious_idle: busy=%b start=%b count=%0d need 0/0/0", busy, gen_start, queue_count); end
    applyStimulus(randValid());
    e = expQ.pop_front();
    gen_done = 1'b1;
    repeat (2) @(negedge clk);
    gen_done = 1'b0;
    total++;
    if (gen_start !== 1'b1 || genNow() !== e)
      begin bad++; $display("[TB] FAIL spurious_start: start=%b gen=%h need 1/%h", gen_start, genNow(), e); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b1 || gen_start !== 1'b0 || genNow() !== e)
        begin bad++; $display("[TB] FAIL spurious_wait: busy=%b start=%b gen=%h need 1/0/%h", busy, gen_start, genNow(), e); end
    end
    for (int i = 0; i < 4; i++) applyStimulus(randValid());
    total++;
    if (queue_count !== 4'd4) begin bad++; $display("[TB] FAIL steady_fill: got %0d need 4", queue_count); end
    finishDraw(0);
    applyStimulus(randValid());
    total++;
    if (queue_count !== 4'd4) begin bad++; $display("[TB] FAIL steady_push_pop: got %0d need 4", queue_count); end
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      waitStart(20, seen, cyc, obs);
      total++;
      if (!seen || obs !== e) begin bad++; $display("[TB] FAIL steady_order: seen=%b got %h need %h", seen, obs, e); end
      finishDraw($urandom_range(1, 3));
    end
  endtask

  task automatic test_reset_mid_draw;
    rect_cmd_t e, obs;
    bit seen;
    int cyc, starts;
    applyStimulus(randValid());
    e = expQ.pop_front();
    waitStart(10, seen, cyc, obs);
    total++;
    if (!seen || obs !== e) begin bad++; $display("[TB] FAIL rst_pre_issue: seen=%b got %h need %h", seen, obs, e); end
    for (int i = 0; i < 3; i++) applyStimulus(randValid());
    total++;
    if (queue_count !== 4'd3 || busy !== 1'b1)
      begin bad++; $display("[TB] FAIL rst_pre_state: count=%0d busy=%b need 3/1", queue_count, busy); end
    reset_n = 1'b0;
    #1;
    total++;
    if ({cmd_ready, gen_start, busy, genNow(), queue_count, drop_count} !== '0)
      begin bad++; $display("[TB] FAIL rst_mid_outputs: ready=%b start=%b busy=%b gen=%h count=%0d drops=%0d, need all 0",
        cmd_ready, gen_start, busy, genNow(), queue_count, drop_count); end
    expQ.delete();
    modelDrops = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    starts  = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (gen_start === 1'b1) starts++;
    end
    total++;
    if (starts != 0 || queue_count !== 4'd0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      begin bad++; $display("[TB] FAIL rst_after_release: starts=%0d count=%0d busy=%b ready=%b need 0/0/0/1",
        starts, queue_count, busy, cmd_ready); end
  endtask

  task automatic test_random;
    rect_cmd_t e, obs;
    bit seen;
    int cyc;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < int'($urandom_range(1, 6)); k++) applyStimulus(randAny());
      while (expQ.size() > 0) begin
        e = expQ.pop_front();
        waitStart(60, seen, cyc, obs);
        total++;
        if (!seen || obs !== e) begin bad++; $display("[TB] FAIL rand_issue: round=%0d seen=%b got %h need %h", r, seen, obs, e); end
        finishDraw($urandom_range(1, 3));
      end
      waitIdle(40);
      total++;
      if (busy !== 1'b0 || queue_count !== 4'd0 || drop_count !== 8'(modelDrops))
        begin bad++; $display("[TB] FAIL rand_idle: busy=%b count=%0d drops=%0d need 0/0/%0d", busy, queue_count, drop_count, modelDrops); end
    end
  endtask

  task automatic test_drop_saturate;
    rect_cmd_t c;
    for (int i = 0; i < 300; i++) begin
      c   = randAny();
      c.w = '0;
      applyStimulus(c);
    end
    waitIdle(50);
    total++;
    if (drop_count !== 8'd255 || modelDrops != 255)
      begin bad++; $display("[TB] FAIL drop_saturate: got %0d model %0d need 255", drop_count, modelDrops); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_drops();
    test_clip();
    test_spurious_done();
    test_reset_mid_draw();
    test_random();
    test_drop_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
